seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Time-multiplexed scan controller for a common-anode, active-low multi-digit 7-segment display. It shares one segment/decimal-point bus among `NUM_DIGITS` digit enables. Each digit gets a fixed refresh slot, and a blanking gap at the start of each slot suppresses ghosting. Digit values are written through a valid/ready port into shadow registers and become visible only at a frame boundary after a commit request, so a multi-digit update never tears.

## Interface
- `NUM_DIGITS`, default 4: digit count, 2..8.
- `REFRESH_DIV`, default 50000: clk cycles per digit slot; must be greater than `BLANK_CYCLES`.
- `BLANK_CYCLES`, default 1000: cycles at the start of each slot with all digits off; must be at least 1.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  write accepted when high together with `wr_valid`.
- `wr_digit`  in  `$clog2(NUM_DIGITS)`  target digit; index 0 is least significant.
- `wr_value`  in  4  hex value 0x0..0xF.
- `wr_dp`  in  1  decimal point on for that digit.
- `commit`  in  1  pulse: request shadow-to-active copy at the next frame boundary.
- `lzb_en`  in  1  leading-zero blanking enable.
- `seg_n`  out  7  segments, active-low; bit0=a … bit6=g.
- `dp_n`  out  1  decimal point, active-low.
- `an_n`  out  `NUM_DIGITS`  digit enables, active-low, one-cold or all-high.
- `frame_start`  out  1  one-cycle pulse at cycle 0 of slot 0.
- `busy_commit`  out  1  a commit is pending and not yet applied.

## Operation
- Slot counter `cnt` runs 0..`REFRESH_DIV`-1. At wrap, digit index `idx` advances from 0 to `NUM_DIGITS`-1 and then wraps back to 0.
- FSM states:
  - BLANK: `cnt` < `BLANK_CYCLES`. `an_n` all high, `seg_n`=7'h7F, `dp_n`=1.
  - DRIVE: remainder of the slot. `an_n[idx]`=0. `seg_n`/`dp_n` are the decode of active digit `idx`.
- Decode is standard hex, active-low. Examples: 0→7'b1000000, 1→7'b1111001, 8→7'b0000000, 9→7'b0010000, A→7'b0001000, F→7'b0001110.
- Write: `wr_ready`=1 whenever not in reset. On `wr_valid`&`wr_ready`, `shadow[wr_digit]` ← {`wr_dp`, `wr_value`}.
- Commit:
  - `commit` sets the pending flag (`busy_commit`).
  - The frame boundary is the cycle where `cnt`=`REFRESH_DIV`-1 and `idx`=`NUM_DIGITS`-1. On that cycle, if pending is set or `commit` is high, active ← shadow (all digits) and pending clears.
  - A write in the boundary cycle lands in shadow only and is not part of that copy.
- Leading-zero blanking: when `lzb_en`=1, digit k>0 is blanked (`seg_n`=7'h7F) if its active value and all active values above it are 0. Digit 0 is never blanked. `dp_n` is unaffected, and `an_n` still asserts.
- Changing `lzb_en` takes effect at the next DRIVE entry.

## Timing
- Reset values: `cnt`=0, `idx`=0, state BLANK, shadow and active all 0 with dp off, pending=0, `wr_ready`=0, `seg_n`=7'h7F, `dp_n`=1, `an_n` all high, `frame_start`=0, `busy_commit`=0.
- All outputs are registered, with no combinational input-to-output path.
- Cycle 0 is the first cycle with `rst` low.
  - For slot s, `an_n[s mod NUM_DIGITS]` is low during cycles s·`REFRESH_DIV`+`BLANK_CYCLES` … (s+1)·`REFRESH_DIV`-1.
  - `frame_start` is high at cycle f·`NUM_DIGITS`·`REFRESH_DIV`, including cycle 0.
- Commit latency: the new value appears at the start of the next frame's slot-0 DRIVE. Worst case is one full frame plus `BLANK_CYCLES`.
- Reset asserted mid-slot or mid-commit: the next cycle shows reset values, and the pending commit is discarded.

## Structure
- Package `seg7_pkg` holds:
  - `seg7_t` (logic [6:0]);
  - constants `SEG7_BLANK`=7'h7F and `SEG7_HEX[16]` (the active-low patterns);
  - function `seg7_decode(logic [3:0])`.
- Sub-module `seg7_decode`: combinational hex-to-segment decoder, shared with the existing single-digit counter design. The scan FSM, counters, shadow/active banks and commit logic stay in `seg7_scan_ctrl`.

## Test plan
All scenarios use `NUM_DIGITS`=4, `REFRESH_DIV`=8, `BLANK_CYCLES`=2.
- Release reset, idle → `an_n`=4'b1111 at cycles 0–1; `an_n`=4'b1110 at cycles 2–7; `an_n`=4'b1101 at cycles 10–15; `frame_start` at cycles 0, 32, 64; `seg_n`=7'b1000000 while driving.
- Write digits 3..0 = 1,2,3,4, then no commit → display stays all 0 for 3 frames; `busy_commit`=0.
- Same writes plus `commit` at cycle 5 → `busy_commit` high at cycles 6–31; digit 0 shows 7'b0011001 (4) from cycle 34; digit 3 shows 7'b1111001 (1).
- Active 0,0,7,0 (digit 3..0), `lzb_en`=1 → digits 3 and 2 blank (7'h7F); digit 1 shows 7'b1111000; digit 0 shows 7'b1000000. Set digit 0's `wr_dp`=1 and commit → `dp_n`=0 only in digit 0's DRIVE.
- Write to digit 2 and `commit` in the same boundary cycle (cycle 31) → the copy uses the old shadow; the new value appears only after a second commit.
- Assert `rst` at cycle 20 with a commit pending → next cycle all reset values; `busy_commit`=0; no display change after release.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment types, active-low hex patterns and decode helper
package seg7_pkg;
  typedef logic [6:0] seg7_t;
  localparam seg7_t SEG7_BLANK = 7'h7F;
  localparam seg7_t SEG7_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  function automatic seg7_t seg7_decode(input logic [3:0] v);
    return SEG7_HEX[v];
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex to active-low segment decoder
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output seg7_t      seg
);
  assign seg = seg7_pkg::seg7_decode(hex);
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-seg scanner with blanking gap and frame-synchronous commit
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_digit,
  input  logic [3:0]                    wr_value,
  input  logic                          wr_dp,
  input  logic                          commit,
  input  logic                          lzb_en,
  output seg7_t                         seg_n,
  output logic                          dp_n,
  output logic [NUM_DIGITS-1:0]         an_n,
  output logic                          frame_start,
  output logic                          busy_commit
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BL = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] TOP = IW'(NUM_DIGITS - 1);
  typedef enum logic {BLANK, DRIVE} state_t;
  state_t state;
  logic [CW-1:0] cnt, nc;
  logic [IW-1:0] idx, ni;
  logic [4:0] shadow [NUM_DIGITS];
  logic [4:0] active [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lz;
  logic last, bnd, blank_lz;
  seg7_t dec;
  // cnt/idx name the cycle currently shown; wr_ready doubles as "running" so cycle 0 is held once
  always_comb begin
    logic z;
    last = wr_ready && cnt == LAST;
    bnd = last && idx == TOP;
    nc = (!wr_ready || last) ? '0 : cnt + 1'b1;
    ni = !last ? idx : (idx == TOP ? '0 : idx + 1'b1);
    z = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      z = z && active[k][3:0] == 4'h0;
      lz[k] = z;
    end
    blank_lz = lzb_en && ni != '0 && lz[ni];
  end
  seg7_decode u_dec (.hex(active[ni][3:0]), .seg(dec));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BLANK;
      cnt <= '0;
      idx <= '0;
      wr_ready <= 1'b0;
      busy_commit <= 1'b0;
      frame_start <= 1'b0;
      seg_n <= SEG7_BLANK;
      dp_n <= 1'b1;
      an_n <= '1;
    end else begin
      wr_ready <= 1'b1;
      cnt <= nc;
      idx <= ni;
      frame_start <= nc == '0 && ni == '0;
      busy_commit <= !bnd && (busy_commit || (wr_ready && commit));
      if (nc < BL) begin
        state <= BLANK;
        an_n <= '1;
        seg_n <= SEG7_BLANK;
        dp_n <= 1'b1;
      end else if (state == BLANK) begin
        state <= DRIVE;
        an_n <= ~(NUM_DIGITS'(1) << ni);
        seg_n <= blank_lz ? SEG7_BLANK : dec;
        dp_n <= ~active[ni][4];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      if (bnd && (busy_commit || commit))
        for (int k = 0; k < NUM_DIGITS; k++) active[k] <= shadow[k];
      if (wr_valid && wr_ready && wr_digit <= TOP)
        shadow[wr_digit] <= {wr_dp, wr_value};
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed and random checks of the scan controller against a cycle-arithmetic model
module tb_seg7_scan_ctrl;
  localparam int ND = 4, RD = 8, BL = 2, FR = ND * RD;
  logic clk = 0, rst = 1, wr_valid = 0, wr_dp = 0, commit = 0, lzb_en = 0;
  logic [1:0] wr_digit = '0;
  logic [3:0] wr_value = '0;
  logic wr_ready, frame_start, busy_commit, dp_n;
  logic [6:0] seg_n;
  logic [3:0] an_n;
  seg7_scan_ctrl #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_digit(wr_digit),
    .wr_value(wr_value), .wr_dp(wr_dp), .commit(commit), .lzb_en(lzb_en), .seg_n(seg_n),
    .dp_n(dp_n), .an_n(an_n), .frame_start(frame_start), .busy_commit(busy_commit)
  );
  always #5 clk = ~clk;
  int passed = 0, total = 0, mn = 0;
  bit rflag = 1, m_pend = 0, m_lzb = 0, lz_r = 0;
  logic [4:0] m_sh [ND];
  logic [4:0] m_act [ND];
  logic [6:0] hex_ref [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, mn, act, exp);
  endtask
  task automatic expect_now();
    int pos, d;
    bit z;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp;
    if (rflag) begin
      chk("rst_an", an_n, 4'hF);
      chk("rst_seg", seg_n, 7'h7F);
      chk("rst_dp", dp_n, 1);
      chk("rst_ready", wr_ready, 0);
      chk("rst_busy", busy_commit, 0);
      chk("rst_fs", frame_start, 0);
    end else begin
      pos = mn % RD;
      d = (mn / RD) % ND;
      z = 1;
      for (int j = d; j < ND; j++) z = z && m_act[j][3:0] == 4'h0;
      e_an = 4'hF;
      e_seg = 7'h7F;
      e_dp = 1;
      if (pos >= BL) begin
        e_an[d] = 1'b0;
        e_seg = (m_lzb && d > 0 && z) ? 7'h7F : hex_ref[m_act[d][3:0]];
        e_dp = ~m_act[d][4];
      end
      chk("an", an_n, e_an);
      chk("seg", seg_n, e_seg);
      chk("dp", dp_n, e_dp);
      chk("fs", frame_start, mn % FR == 0);
      chk("busy", busy_commit, m_pend);
      chk("ready", wr_ready, 1);
    end
  endtask
  task automatic tick(input bit r, input bit v, input logic [1:0] dg, input logic [3:0] val,
                      input bit dp, input bit c, input bit l);
    expect_now();
    rst = r; wr_valid = v; wr_digit = dg; wr_value = val; wr_dp = dp; commit = c; lzb_en = l;
    if (r) begin
      rflag = 1;
      m_pend = 0;
      for (int k = 0; k < ND; k++) begin m_sh[k] = '0; m_act[k] = '0; end
    end else if (rflag) begin
      rflag = 0;
      mn = 0;
    end else begin
      if (mn % FR == FR - 1) begin
        if (m_pend || c) for (int k = 0; k < ND; k++) m_act[k] = m_sh[k];
        m_pend = 0;
      end else if (c) m_pend = 1;
      if (v) m_sh[dg] = {dp, val};
      if (mn % RD == BL - 1) m_lzb = l;
      mn++;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input bit l);
    tick(0, 0, 2'd0, 4'd0, 0, 0, l);
  endtask
  task automatic do_reset();
    tick(1, 0, 2'd0, 4'd0, 0, 0, 0);
    tick(1, 0, 2'd0, 4'd0, 0, 0, 0);
    idle(0);
  endtask
  initial begin
    for (int k = 0; k < ND; k++) begin m_sh[k] = '0; m_act[k] = '0; end
    @(posedge clk);
    #1;
    do_reset();
    for (int n = 0; n < 70; n++) begin
      if (n == 0) chk("s1_fs0", frame_start, 1);
      if (n == 1) chk("s1_an1", an_n, 4'b1111);
      if (n == 2) begin chk("s1_an2", an_n, 4'b1110); chk("s1_seg2", seg_n, 7'b1000000); end
      if (n == 7) chk("s1_an7", an_n, 4'b1110);
      if (n == 8) chk("s1_an8", an_n, 4'b1111);
      if (n == 10) chk("s1_an10", an_n, 4'b1101);
      if (n == 32) chk("s1_fs32", frame_start, 1);
      if (n == 33) chk("s1_fs33", frame_start, 0);
      if (n == 64) chk("s1_fs64", frame_start, 1);
      idle(0);
    end
    do_reset();
    for (int n = 0; n < 100; n++) begin
      if (n == 10) chk("s2_busy", busy_commit, 0);
      if (n == 34 || n == 90) chk("s2_seg_d0", seg_n, 7'b1000000);
      if (n == 58) chk("s2_seg_d3", seg_n, 7'b1000000);
      if (n < 4) tick(0, 1, 2'(3 - n), 4'(n + 1), 0, 0, 0);
      else idle(0);
    end
    do_reset();
    for (int n = 0; n < 70; n++) begin
      if (n == 2) chk("s3_seg_old", seg_n, 7'b1000000);
      if (n == 5) chk("s3_busy5", busy_commit, 0);
      if (n == 6) chk("s3_busy6", busy_commit, 1);
      if (n == 31) chk("s3_busy31", busy_commit, 1);
      if (n == 32) chk("s3_busy32", busy_commit, 0);
      if (n == 33) chk("s3_seg33", seg_n, 7'h7F);
      if (n == 34) chk("s3_seg34", seg_n, 7'b0011001);
      if (n == 58) chk("s3_seg58", seg_n, 7'b1111001);
      if (n < 4) tick(0, 1, 2'(3 - n), 4'(n + 1), 0, 0, 0);
      else tick(0, 0, 2'd0, 4'd0, 0, n == 5, 0);
    end
    do_reset();
    for (int n = 0; n < 96; n++) begin
      if (n == 34) chk("s4_d0", seg_n, 7'b1000000);
      if (n == 42) chk("s4_d1", seg_n, 7'b1111000);
      if (n == 50) chk("s4_d2", seg_n, 7'h7F);
      if (n == 58) begin chk("s4_d3", seg_n, 7'h7F); chk("s4_an3", an_n, 4'b0111); chk("s4_dp3", dp_n, 1); end
      if (n == 66) begin chk("s4_dp0", dp_n, 0); chk("s4_an0", an_n, 4'b1110); end
      if (n == 74) chk("s4_dp1", dp_n, 1);
      if (n == 0) tick(0, 1, 2'd1, 4'd7, 0, 0, 1);
      else if (n == 40) tick(0, 1, 2'd0, 4'd0, 1, 0, 1);
      else tick(0, 0, 2'd0, 4'd0, 0, n == 1 || n == 41, 1);
    end
    do_reset();
    for (int n = 0; n < 128; n++) begin
      if (n == 32) chk("s5_busy32", busy_commit, 0);
      if (n == 50) chk("s5_old50", seg_n, 7'b0110000);
      if (n == 82) chk("s5_old82", seg_n, 7'b0110000);
      if (n == 114) chk("s5_new114", seg_n, 7'b0010010);
      if (n == 0) tick(0, 1, 2'd2, 4'd3, 0, 0, 0);
      else if (n == 31) tick(0, 1, 2'd2, 4'd5, 0, 1, 0);
      else tick(0, 0, 2'd0, 4'd0, 0, n == 70, 0);
    end
    do_reset();
    for (int n = 0; n <= 20; n++) begin
      if (n == 4) chk("s6_busy4", busy_commit, 1);
      if (n == 1) tick(0, 1, 2'd0, 4'd9, 0, 0, 0);
      else tick(n == 20, 0, 2'd0, 4'd0, 0, n == 3, 0);
    end
    chk("s6_busy_rst", busy_commit, 0);
    chk("s6_an_rst", an_n, 4'hF);
    idle(0);
    for (int n = 0; n < 40; n++) begin
      if (n == 2 || n == 34) chk("s6_seg", seg_n, 7'b1000000);
      if (n == 5) chk("s6_busy", busy_commit, 0);
      idle(0);
    end
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 63) == 0) lz_r = ~lz_r;
      tick($urandom_range(0, 399) == 0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0, lz_r);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
